// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported data memory with registered reads.
// Port 0 (pipeline) has priority, and a starvation counter bounds port 1's wait.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rt_valid_q, rt_valid_d;
    logic       rt_port_q, rt_port_d;

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt;
    // the request is consumed in the cycle where req & gnt are both high.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (m1_req && (starve_cnt_q == LIMIT)) begin
            m1_gnt = 1'b1;
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end

        mem_addr  = m1_gnt ? m1_addr  : m0_addr;
        mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
        mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);

        starve_cnt_d = starve_cnt_q;
        if (!m1_req || m1_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // Owner of the read in flight; the memory returns its word next cycle.
        rt_valid_d = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
        rt_port_d  = rt_valid_d ? m1_gnt : rt_port_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            rt_valid_q   <= 1'b0;
            rt_port_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rt_valid_q   <= rt_valid_d;
            rt_port_q    <= rt_port_d;
        end
    end

    always_comb begin
        m0_rvalid = rt_valid_q & ~rt_port_q;
        m1_rvalid = rt_valid_q &  rt_port_q;
        m0_rdata  = m0_rvalid ? mem_rdata : 32'd0;
        m1_rdata  = m1_rvalid ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a registered-read memory model, a table of
// per-cycle vectors, and hand-written sequences around reset.
module tb_dmem_arbiter;

    localparam logic [31:0] DA = 32'h12345678;
    localparam logic [31:0] DB = 32'hAAAA0000;
    localparam logic [31:0] DC = 32'h5555FFFF;
    localparam logic [31:0] DW = 32'hDEADBEEF;
    localparam logic [31:0] DX = 32'hCAFEF00D;

    logic        clk, rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // registered-read, read-before-write memory; preloaded while in reset
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[8'h04] <= DA;
            mem[8'h10] <= DB;
            mem[8'h11] <= DC;
            mem_rdata  <= 32'd0;
        end else begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, we;
        logic [31:0] addr;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic drive_idle();
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic add_contention_rows();
        // both ports read continuously: m0 at 0x10 (DA), m1 at 0x40 (DB)
        vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 1,0,0,32'h10, 0,0,0,0});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 1,0,0,32'h10, 1,DA,0,0});
        vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 0,1,0,32'h40, 1,DA,0,0});
        vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 1,0,0,32'h10, 0,0,1,DB});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 1,0,0,32'h10, 1,DA,0,0});
        vecs.push_back('{1,0,32'h10,0, 1,0,32'h40,0, 0,1,0,32'h40, 1,DA,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,DB});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        #2;
        check("reset_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("reset_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("reset_m0_rdata",  m0_rdata, 32'd0);
        check("reset_m1_rdata",  m1_rdata, 32'd0);
        check("reset_gnt",       {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("reset_mem_we",    32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // m0 read alone
        vecs.push_back('{1,0,32'h10,0, 0,0,0,0, 1,0,0,32'h10, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 1,DA,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        add_contention_rows();
        // write then read of the same word
        vecs.push_back('{1,1,32'h20,DW, 0,0,0,0, 1,0,1,32'h20, 0,0,0,0});
        vecs.push_back('{1,0,32'h20,0, 0,0,0,0, 1,0,0,32'h20, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 1,DW,0,0});
        // interleaved returns
        vecs.push_back('{0,0,0,0, 1,0,32'h40,0, 0,1,0,32'h40, 0,0,0,0});
        vecs.push_back('{1,0,32'h44,0, 0,0,0,0, 1,0,0,32'h44, 0,0,1,DB});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 1,DC,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        // m1 write has no return; later read sees the data
        vecs.push_back('{0,0,0,0, 1,1,32'h08,DX, 0,1,1,32'h08, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 1,0,32'h08,0, 0,1,0,32'h08, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,DX});

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("v%0d_m0_gnt", i),    32'(m0_gnt),    32'(vecs[i].g0));
            check($sformatf("v%0d_m1_gnt", i),    32'(m1_gnt),    32'(vecs[i].g1));
            check($sformatf("v%0d_mem_we", i),    32'(mem_we),    32'(vecs[i].we));
            check($sformatf("v%0d_mem_addr", i),  mem_addr,       vecs[i].addr);
            check($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].rv0));
            check($sformatf("v%0d_m0_rdata", i),  m0_rdata,       vecs[i].rd0);
            check($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].rv1));
            check($sformatf("v%0d_m1_rdata", i),  m1_rdata,       vecs[i].rd1);
            if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].r0 ? vecs[i].d0 : vecs[i].d1);
        end

        // reset between grant and return drops the pending read
        @(posedge clk);
        #1;
        drive(1, 0, 32'h10, 32'd0, 1, 0, 32'h40, 32'd0);
        @(negedge clk);
        check("rst_seq_gnt", 32'(m0_gnt), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        check("rst_seq_pending_rv", 32'(m0_rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_seq_rv_drop",   32'(m0_rvalid), 32'd0);
        check("rst_seq_rd_drop",   m0_rdata, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rst_seq_no_rv0_%0d", k), 32'(m0_rvalid), 32'd0);
            check($sformatf("rst_seq_no_rv1_%0d", k), 32'(m1_rvalid), 32'd0);
        end

        // starvation counter restarts from zero: m1 wins on the fifth cycle
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            drive(1, 0, 32'h10, 32'd0, 1, 0, 32'h40, 32'd0);
            @(negedge clk);
            check($sformatf("post_rst_m1_gnt_%0d", k), 32'(m1_gnt), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("post_rst_m0_gnt_%0d", k), 32'(m0_gnt), (k == 4) ? 32'd0 : 32'd1);
        end
        @(posedge clk);
        #1;
        drive_idle();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
